// File: rtl/layer_out_packer.sv
// Purpose : packs serially streamed output-layer scores into a flat bus and hands it to the argmax comparator.
// Latency : valid_o rises the cycle after the final word is accepted; COLLECT resumes the cycle after cmp_ready_i.
// Backpr. : in_ready_o is low for the ISSUE and WAIT cycles, so frames never overlap; WAIT ends on cmp_ready_i or timeout.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   in_valid_i/in_ready_o          score stream handshake; in_data_i is the score, in_last_i ends a frame
//   layer_out_o                    class k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_o / cmp_ready_i          one-cycle offer to the comparator / its acknowledge
//   busy_o                         high in ISSUE and WAIT
//   frame_err_o                    one-cycle pulse on early last, missing last or comparator timeout
//   frames_done_o                  count of issued frames, wraps at 2^16
module layer_out_packer #(
    parameter int DATA_WIDTH  = 40,
    parameter int NUM_CLASSES = 10,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [DATA_WIDTH-1:0]             in_data_i,
    input  logic                              in_last_i,
    output logic [DATA_WIDTH*NUM_CLASSES-1:0] layer_out_o,
    output logic                              valid_o,
    input  logic                              cmp_ready_i,
    output logic                              busy_o,
    output logic                              frame_err_o,
    output logic [15:0]                       frames_done_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(NUM_CLASSES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2
    } state_t;

    state_t                              state_q;
    logic [CNT_W-1:0]                    cnt_q;
    logic [TMR_W-1:0]                    timer_q;
    logic [DATA_WIDTH*NUM_CLASSES-1:0]   layer_out_q;
    logic                                valid_q;
    logic                                busy_q;
    logic                                frame_err_q;
    logic [15:0]                         frames_done_q;

    logic [CNT_W-1:0]                    cnt_d;
    logic [TMR_W-1:0]                    timer_d;
    logic [15:0]                         frames_done_d;
    logic                                accept;

    // Gated by reset so the producer never sees ready while the block is held in reset.
    assign in_ready_o    = (state_q == S_COLLECT) && rst_ni;
    assign accept        = in_valid_i && in_ready_o;

    assign cnt_d         = cnt_q + 1'b1;
    assign timer_d       = timer_q + 1'b1;
    assign frames_done_d = frames_done_q + 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_COLLECT;
            cnt_q         <= '0;
            timer_q       <= '0;
            layer_out_q   <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            frames_done_q <= '0;
        end else begin
            // Pulse outputs default low; each branch below raises them for one cycle only.
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            if (cnt_q == CNT_W'(k)) begin
                                layer_out_q[k*DATA_WIDTH +: DATA_WIDTH] <= in_data_i;
                            end
                        end
                        if (cnt_q == LAST_SLOT) begin
                            // Full frame: issue it even when in_last is missing, but flag it.
                            state_q       <= S_ISSUE;
                            cnt_q         <= '0;
                            valid_q       <= 1'b1;
                            busy_q        <= 1'b1;
                            frames_done_q <= frames_done_d;
                            frame_err_q   <= ~in_last_i;
                        end else if (in_last_i) begin
                            // Short frame: drop it; stale slots get overwritten by the next frame.
                            cnt_q       <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    timer_q <= '0;
                end
                S_WAIT: begin
                    // An acknowledge on the timeout edge wins: no error in that case.
                    if (cmp_ready_i) begin
                        state_q <= S_COLLECT;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                    end else if (timer_q == TMO_LAST) begin
                        state_q     <= S_COLLECT;
                        busy_q      <= 1'b0;
                        timer_q     <= '0;
                        frame_err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                default: begin
                    state_q <= S_COLLECT;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign layer_out_o   = layer_out_q;
    assign valid_o       = valid_q;
    assign busy_o        = busy_q;
    assign frame_err_o   = frame_err_q;
    assign frames_done_o = frames_done_q;

endmodule

// File: tb/tb_layer_out_packer.sv
// Directed bench for layer_out_packer: streams frames, checks packing, pulses, timeout and async reset.
module tb_layer_out_packer;

    localparam int DW = 40;
    localparam int NC = 10;
    localparam int BW = DW * NC;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic [BW-1:0]   layer_out;
    logic            valid;
    logic            cmp_ready;
    logic            busy;
    logic            frame_err;
    logic [15:0]     frames_done;

    int passes = 0;
    int fails  = 0;

    layer_out_packer #(
        .DATA_WIDTH (DW),
        .NUM_CLASSES(NC),
        .CNT_W      (4),
        .TIMEOUT    (15)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .layer_out_o  (layer_out),
        .valid_o      (valid),
        .cmp_ready_i  (cmp_ready),
        .busy_o       (busy),
        .frame_err_o  (frame_err),
        .frames_done_o(frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [DW-1:0] slot(input int k);
        logic [BW-1:0] v;
        v = layer_out;
        return v[k*DW +: DW];
    endfunction

    // Called in the ISSUE cycle: comparator acks 2 cycles after valid.
    task automatic ack_frame(input string tag);
        step();
        check({tag, "_wait_valid"}, BW'(valid), BW'(0));
        check({tag, "_wait_rdy"}, BW'(in_ready), BW'(0));
        step();
        check({tag, "_wait2_rdy"}, BW'(in_ready), BW'(0));
        cmp_ready = 1'b1;
        step();
        cmp_ready = 1'b0;
        check({tag, "_back_rdy"}, BW'(in_ready), BW'(1));
        check({tag, "_back_busy"}, BW'(busy), BW'(0));
        check({tag, "_back_err"}, BW'(frame_err), BW'(0));
    endtask

    initial begin
        logic [BW-1:0]        exp_bus;
        logic [BW-1:0]        snap;
        logic signed [DW-1:0] sv;
        logic signed [DW-1:0] best;
        int                   best_k;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        cmp_ready = 1'b0;
        step();
        step();
        check("rst_rdy_low", BW'(in_ready), BW'(0));
        rst_n = 1'b1;
        #1;
        check("rst_layer_out", layer_out, '0);
        check("rst_valid", BW'(valid), BW'(0));
        check("rst_busy", BW'(busy), BW'(0));
        check("rst_err", BW'(frame_err), BW'(0));
        check("rst_frames", BW'(frames_done), BW'(0));
        check("rst_rdy_high", BW'(in_ready), BW'(1));

        // 1: back-to-back frame, word k = k+1.
        for (int k = 0; k < NC; k++) begin
            send(DW'(k + 1), k == NC - 1);
            if (k < NC - 1) check("t1_valid_early", BW'(valid), BW'(0));
        end
        check("t1_slot0", BW'(slot(0)), BW'(40'd1));
        check("t1_slot9", BW'(slot(9)), BW'(40'h0A));
        check("t1_valid", BW'(valid), BW'(1));
        check("t1_busy", BW'(busy), BW'(1));
        check("t1_rdy", BW'(in_ready), BW'(0));
        check("t1_frames", BW'(frames_done), BW'(1));
        check("t1_err", BW'(frame_err), BW'(0));
        ack_frame("t1");

        // 2: comparator-style scores with 1-3 idle cycles between words.
        exp_bus = '0;
        for (int k = 0; k < NC; k++) begin
            sv = (k == 2) ? -40'sd5 : (k == 7) ? 40'sd3 : -40'sd100;
            exp_bus[k*DW +: DW] = sv;
            send(sv, k == NC - 1);
            if (k < NC - 1) begin
                repeat ($urandom_range(1, 3)) begin
                    step();
                    check("t2_valid_gap", BW'(valid), BW'(0));
                end
            end
        end
        check("t2_bus", layer_out, exp_bus);
        check("t2_valid", BW'(valid), BW'(1));
        check("t2_frames", BW'(frames_done), BW'(2));
        best   = $signed(slot(0));
        best_k = 0;
        for (int k = 1; k < NC; k++) begin
            if ($signed(slot(k)) > best) begin
                best   = $signed(slot(k));
                best_k = k;
            end
        end
        check("t2_predict", BW'(best_k), BW'(7));
        ack_frame("t2");

        // 3: early last on the fourth word, then a full frame.
        for (int k = 0; k < 4; k++) send(DW'(11 + k), k == 3);
        check("t3_err", BW'(frame_err), BW'(1));
        check("t3_valid", BW'(valid), BW'(0));
        check("t3_rdy", BW'(in_ready), BW'(1));
        check("t3_frames", BW'(frames_done), BW'(2));
        step();
        check("t3_err_once", BW'(frame_err), BW'(0));
        for (int k = 0; k < NC; k++) send(DW'(100 + k), k == NC - 1);
        check("t3_slot0", BW'(slot(0)), BW'(40'd100));
        check("t3_slot3", BW'(slot(3)), BW'(40'd103));
        check("t3_slot9", BW'(slot(9)), BW'(40'd109));
        check("t3_valid", BW'(valid), BW'(1));
        check("t3_frames2", BW'(frames_done), BW'(3));
        ack_frame("t3");

        // 4: full frame with no in_last: error and valid together.
        for (int k = 0; k < NC; k++) send(DW'(200 + k), 1'b0);
        check("t4_valid", BW'(valid), BW'(1));
        check("t4_err", BW'(frame_err), BW'(1));
        check("t4_frames", BW'(frames_done), BW'(4));
        ack_frame("t4");

        // 5: comparator never acks; negative scores must pass through unmodified.
        for (int k = 0; k < NC; k++) begin
            sv = -(k + 1);
            send(sv, k == NC - 1);
        end
        check("t5_slot0", BW'(slot(0)), BW'(40'hFF_FFFF_FFFF));
        check("t5_slot9", BW'(slot(9)), BW'(40'hFF_FFFF_FFF6));
        check("t5_valid", BW'(valid), BW'(1));
        snap = layer_out;
        step();
        for (int i = 1; i < 15; i++) begin
            step();
            check("t5_wait_err", BW'(frame_err), BW'(0));
            check("t5_wait_rdy", BW'(in_ready), BW'(0));
            check("t5_hold", layer_out, snap);
        end
        step();
        check("t5_timeout_err", BW'(frame_err), BW'(1));
        check("t5_timeout_rdy", BW'(in_ready), BW'(1));
        check("t5_timeout_busy", BW'(busy), BW'(0));
        check("t5_frames", BW'(frames_done), BW'(5));

        // 5b: acknowledge lands on the timeout edge: success, no error.
        for (int k = 0; k < NC; k++) send(DW'(k), k == NC - 1);
        step();
        repeat (14) step();
        check("t5b_still_wait", BW'(in_ready), BW'(0));
        cmp_ready = 1'b1;
        step();
        cmp_ready = 1'b0;
        check("t5b_err", BW'(frame_err), BW'(0));
        check("t5b_rdy", BW'(in_ready), BW'(1));

        // 6: async reset mid-frame, then mid-WAIT, then a fresh frame.
        for (int k = 0; k < 5; k++) send(DW'(50 + k), 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6a_bus", layer_out, '0);
        check("t6a_frames", BW'(frames_done), BW'(0));
        check("t6a_rdy", BW'(in_ready), BW'(0));
        step();
        rst_n = 1'b1;
        #1;
        check("t6a_rdy_rel", BW'(in_ready), BW'(1));
        for (int k = 0; k < NC; k++) send(DW'(60 + k), k == NC - 1);
        step();
        check("t6b_busy_pre", BW'(busy), BW'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("t6b_bus", layer_out, '0);
        check("t6b_busy", BW'(busy), BW'(0));
        check("t6b_valid", BW'(valid), BW'(0));
        check("t6b_frames", BW'(frames_done), BW'(0));
        step();
        rst_n = 1'b1;
        #1;
        exp_bus = '0;
        for (int k = 0; k < NC; k++) begin
            exp_bus[k*DW +: DW] = DW'(7 * (k + 1));
            send(DW'(7 * (k + 1)), k == NC - 1);
        end
        check("t6c_bus", layer_out, exp_bus);
        check("t6c_valid", BW'(valid), BW'(1));
        check("t6c_frames", BW'(frames_done), BW'(1));
        ack_frame("t6c");

        $display("%0d/%0d checks passed", passes, passes + fails);
        $finish;
    end

endmodule
